// File: rtl/soc_system_led_pwm_pio.sv
// Avalon-MM LED port with WIDTH channels. Supports atomic set, clear and toggle,
// per-channel PWM dimming with a shadowed duty cycle, and optional blink gating.
module soc_system_led_pwm_pio #(
    parameter int WIDTH    = 8,
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 50
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    typedef enum logic [2:0] {
        REG_DATA   = 3'd0,
        REG_MODE   = 3'd1,
        REG_DUTY   = 3'd2,
        REG_BLINK  = 3'd3,
        REG_SET    = 3'd4,
        REG_CLEAR  = 3'd5,
        REG_TOGGLE = 3'd6,
        REG_STATUS = 3'd7
    } reg_addr_e;

    localparam int              PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [WIDTH-1:0]    data_r;
    logic [WIDTH-1:0]    mode_r;
    logic [PWM_BITS-1:0] duty_r;
    logic [PWM_BITS-1:0] duty_act;
    logic [15:0]         blink_r;
    logic [15:0]         blink_cnt;
    logic                phase;
    logic [PRE_W-1:0]    pre_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;

    logic             wr;
    logic [WIDTH-1:0] wd;
    logic             tick;
    logic             period_end;
    logic             pwm_on;
    logic [WIDTH-1:0] gate;
    reg_addr_e        addr_e;

    // Upper write-data bits are intentionally ignored for narrow registers.
    logic unused_writedata;
    assign unused_writedata = ^writedata;

    assign addr_e     = reg_addr_e'(address);
    assign wr         = chipselect & ~write_n;
    assign wd         = writedata[WIDTH-1:0];
    assign tick       = (pre_cnt == PRE_LAST);
    assign period_end = tick & (&pwm_cnt);
    assign pwm_on     = (pwm_cnt < duty_act);
    assign gate       = {WIDTH{pwm_on & phase}};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_r  <= '0;
            mode_r  <= '0;
            duty_r  <= '0;
            blink_r <= '0;
        end else if (wr) begin
            case (addr_e)
                REG_DATA:   data_r  <= wd;
                REG_MODE:   mode_r  <= wd;
                REG_DUTY:   duty_r  <= writedata[PWM_BITS-1:0];
                REG_BLINK:  blink_r <= writedata[15:0];
                REG_SET:    data_r  <= data_r | wd;
                REG_CLEAR:  data_r  <= data_r & ~wd;
                REG_TOGGLE: data_r  <= data_r ^ wd;
                default:    ;
            endcase
        end
    end

    // NOTE: duty_act samples duty_r with a non-blocking read, so a DUTY write on
    // the same edge as period_end loads the previous value; the new one waits a period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt  <= '0;
            pwm_cnt  <= '0;
            duty_act <= '0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
            if (tick)
                pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            if (period_end)
                duty_act <= duty_r;
        end
    end

    // Blink phase flips every blink_r PWM periods; a BLINK write restarts it high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (wr && addr_e == REG_BLINK) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (blink_r == 16'd0) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (period_end) begin
            if (blink_cnt == blink_r - 16'd1) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            out_port <= '0;
        else
            out_port <= data_r & (~mode_r | gate);
    end

    always_comb begin
        readdata = '0;
        case (addr_e)
            REG_DATA:   readdata = 32'(data_r);
            REG_MODE:   readdata = 32'(mode_r);
            REG_DUTY:   readdata = 32'(duty_r);
            REG_BLINK:  readdata = 32'(blink_r);
            REG_STATUS: readdata = 32'(out_port);
            default:    readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_soc_system_led_pwm_pio.sv
// Bench for soc_system_led_pwm_pio: directed scenarios plus randomized bus traffic,
// compared against a time-based reference model of the LED port.
module tb_soc_system_led_pwm_pio;

    localparam int W   = 8;
    localparam int PB  = 4;
    localparam int P   = 2;
    localparam int PER = P * (1 << PB);

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [W-1:0] out_port;

    int checks = 0;
    int failures = 0;

    soc_system_led_pwm_pio #(.WIDTH(W), .PWM_BITS(PB), .PRESCALE(P)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Reference model: the PWM slot follows from elapsed cycles since reset, the blink
    // phase from the number of whole periods since the last BLINK write.
    int          m_t;
    int          m_duty, m_duty_act, m_blink, m_per;
    logic [W-1:0] m_data, m_mode, m_out;
    int          m_slot;
    logic        m_on;
    logic [W-1:0] m_gate;
    logic        m_pend, m_wr;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_t = 0; m_duty = 0; m_duty_act = 0; m_blink = 0; m_per = 0;
            m_data = '0; m_mode = '0; m_out = '0;
        end else begin
            m_slot = (m_t / P) % (1 << PB);
            m_on   = (m_slot < m_duty_act) && ((m_blink == 0) || (((m_per / m_blink) % 2) == 0));
            m_gate = m_on ? '1 : '0;
            m_out  = m_data & (~m_mode | m_gate);
            m_pend = (m_t % PER) == PER - 1;
            if (m_pend) m_duty_act = m_duty;
            m_wr = chipselect && !write_n;
            if (m_wr && address == 3'd3) m_per = 0;
            else if (m_pend) m_per = m_per + 1;
            if (m_wr) begin
                case (address)
                    3'd0: m_data = writedata[W-1:0];
                    3'd1: m_mode = writedata[W-1:0];
                    3'd2: m_duty = int'(writedata[PB-1:0]);
                    3'd3: m_blink = int'(writedata[15:0]);
                    3'd4: m_data = m_data | writedata[W-1:0];
                    3'd5: m_data = m_data & ~writedata[W-1:0];
                    3'd6: m_data = m_data ^ writedata[W-1:0];
                    default: ;
                endcase
            end
            m_t = m_t + 1;
        end
    end

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0: return 32'(m_data);
            3'd1: return 32'(m_mode);
            3'd2: return 32'(m_duty);
            3'd3: return 32'(m_blink);
            3'd7: return 32'(m_out);
            default: return 32'd0;
        endcase
    endfunction

    // Bus tasks start and end on a falling clock edge.
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; writedata = $urandom;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] got, output logic [31:0] exp);
        chipselect = 1'b1; write_n = 1'b1; address = a;
        #1;
        got = readdata;
        exp = model_read(a);
        @(negedge clk);
        chipselect = 1'b0;
    endtask

    task automatic run_idle(input int n, output int hi, output int bad,
                            output logic [W-1:0] got, output logic [W-1:0] exp);
        hi = 0; bad = 0; got = '0; exp = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (out_port !== m_out) begin
                bad++; got = out_port; exp = m_out;
            end
            if (out_port[0] === 1'b1) hi++;
        end
    endtask

    task automatic wait_mod(input int k);
        for (int g = 0; g < PER && (m_t % PER) != k; g++) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [31:0] got, exp;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        checks++;
        if (out_port !== '0) begin
            failures++; $display("FAIL reset_out: got %h expected 00", out_port);
        end
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), got, exp);
            checks++;
            if (got !== 32'd0) begin
                failures++; $display("FAIL reset_read addr %0d: got %h expected 0", a, got);
            end
        end
    endtask

    task automatic test_set_clear_toggle;
        logic [31:0] got, exp;
        logic [2:0]  addrs [4] = '{3'd0, 3'd4, 3'd5, 3'd6};
        logic [31:0] vals  [4] = '{32'hFFFF_FFA5, 32'h0F, 32'h81, 32'hFF};
        logic [W-1:0] want [4] = '{8'hA5, 8'hAF, 8'h2E, 8'hD1};
        logic [W-1:0] prev;
        prev = out_port;
        for (int i = 0; i < 4; i++) begin
            bus_write(addrs[i], vals[i]);
            checks++;
            if (out_port !== prev) begin
                failures++; $display("FAIL bitop_latency %0d: got %h expected %h", i, out_port, prev);
            end
            @(negedge clk);
            checks++;
            if (out_port !== want[i]) begin
                failures++; $display("FAIL bitop %0d: got %h expected %h", i, out_port, want[i]);
            end
            prev = want[i];
        end
        bus_read(3'd7, got, exp);
        checks++;
        if (got !== 32'h0000_00D1) begin
            failures++; $display("FAIL status: got %h expected 000000d1", got);
        end
        bus_read(3'd4, got, exp);
        checks++;
        if (got !== 32'd0) begin
            failures++; $display("FAIL set_reads_zero: got %h expected 0", got);
        end
    endtask

    task automatic test_pwm;
        int hi, bad;
        logic [W-1:0] g, e;
        int duties [3] = '{4, 0, 15};
        int highs  [3] = '{8, 0, 30};
        bus_write(3'd0, 32'h01);
        bus_write(3'd1, 32'h01);
        for (int i = 0; i < 3; i++) begin
            bus_write(3'd2, 32'(duties[i]));
            run_idle(2 * PER, hi, bad, g, e);
            run_idle(PER, hi, bad, g, e);
            checks++;
            if (hi != highs[i]) begin
                failures++; $display("FAIL pwm_duty%0d_high: got %0d expected %0d", duties[i], hi, highs[i]);
            end
            checks++;
            if (bad != 0) begin
                failures++; $display("FAIL pwm_duty%0d_model: got %h expected %h", duties[i], g, e);
            end
        end
    endtask

    task automatic test_duty_shadow;
        int hi, bad;
        logic [W-1:0] g, e;
        bus_write(3'd2, 32'd4);
        run_idle(2 * PER, hi, bad, g, e);
        wait_mod(0);
        bus_write(3'd2, 32'd12);
        run_idle(PER - 1, hi, bad, g, e);
        checks++;
        if (hi != 7 || bad != 0) begin
            failures++; $display("FAIL duty_mid_old: got %0d high expected 7 (last %h vs %h)", hi, g, e);
        end
        run_idle(PER, hi, bad, g, e);
        checks++;
        if (hi != 24 || bad != 0) begin
            failures++; $display("FAIL duty_mid_new: got %0d high expected 24", hi);
        end
        bus_write(3'd2, 32'd4);
        run_idle(2 * PER, hi, bad, g, e);
        wait_mod(PER - 1);
        bus_write(3'd2, 32'd12);
        run_idle(PER, hi, bad, g, e);
        checks++;
        if (hi != 8 || bad != 0) begin
            failures++; $display("FAIL duty_edge_old: got %0d high expected 8", hi);
        end
        run_idle(PER, hi, bad, g, e);
        checks++;
        if (hi != 24 || bad != 0) begin
            failures++; $display("FAIL duty_edge_new: got %0d high expected 24", hi);
        end
    endtask

    task automatic test_blink;
        int hi, bad;
        logic [W-1:0] g, e;
        int want [4] = '{30, 0, 0, 30};
        bus_write(3'd2, 32'd15);
        run_idle(2 * PER, hi, bad, g, e);
        wait_mod(0);
        bus_write(3'd3, 32'd2);
        run_idle(PER - 1, hi, bad, g, e);
        for (int i = 0; i < 4; i++) begin
            run_idle(PER, hi, bad, g, e);
            checks++;
            if (hi != want[i] || bad != 0) begin
                failures++; $display("FAIL blink_window%0d: got %0d high expected %0d", i, hi, want[i]);
            end
        end
        bus_write(3'd3, 32'd3);
        run_idle(PER - 1, hi, bad, g, e);
        checks++;
        if (hi != 29 || bad != 0) begin
            failures++; $display("FAIL blink_restart: got %0d high expected 29", hi);
        end
        bus_write(3'd3, 32'd0);
        run_idle(PER - 1, hi, bad, g, e);
        run_idle(4 * PER, hi, bad, g, e);
        checks++;
        if (hi != 120 || bad != 0) begin
            failures++; $display("FAIL blink_off: got %0d high expected 120", hi);
        end
    endtask

    task automatic test_random;
        logic [31:0] got, exp;
        logic [2:0]  a;
        int op;
        for (int i = 0; i < 600; i++) begin
            op = $urandom_range(0, 9);
            a  = 3'($urandom_range(0, 7));
            if (op >= 7) begin
                bus_write(a, (a == 3'd3) ? {$urandom_range(0, 65535) * 65536, 32'($urandom_range(0, 3))} : $urandom);
            end else if (op >= 5) begin
                bus_read(a, got, exp);
                checks++;
                if (got !== exp) begin
                    failures++; $display("FAIL rand_read addr %0d: got %h expected %h", a, got, exp);
                end
            end else begin
                @(negedge clk);
            end
            checks++;
            if (out_port !== m_out) begin
                failures++; $display("FAIL rand_out cycle %0d: got %h expected %h", i, out_port, m_out);
            end
        end
    endtask

    task automatic test_async_reset;
        logic [31:0] got, exp;
        bus_write(3'd1, 32'h0F);
        bus_write(3'd0, 32'hFF);
        bus_write(3'd2, 32'd9);
        repeat (2) @(negedge clk);
        checks++;
        if (out_port[7:4] !== 4'hF) begin
            failures++; $display("FAIL pre_reset_out: got %h expected f?", out_port);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (out_port !== '0) begin
            failures++; $display("FAIL async_reset_out: got %h expected 00", out_port);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), got, exp);
            checks++;
            if (got !== 32'd0) begin
                failures++; $display("FAIL post_reset_read addr %0d: got %h expected 0", a, got);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_set_clear_toggle;
        test_pwm;
        test_duty_shadow;
        test_blink;
        test_random;
        test_async_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
